// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver feeding a first-word-fall-through
// byte FIFO. Each bit is decided by a majority vote of three samples taken around
// its centre. A stop bit sampled as 0 raises a frame error and discards the byte.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   uart_rxd   asynchronous serial line, idle high
//   m_data     FIFO head byte (0 while the FIFO is empty)
//   m_valid    FIFO not empty
//   m_ready    consumer accepts the head byte
//   fifo_count number of bytes stored
//   frame_err  one-cycle pulse when a stop bit is sampled as 0
//   overflow   one-cycle pulse when a good byte is dropped on a full FIFO
//
// Handshake: a byte transfers on every rising clk edge where m_valid && m_ready.
// m_data is stable while m_valid=1 and m_ready=0. m_valid does not depend on
// m_ready.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int UART_BPS   = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rxd,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int TICK_RAW = CLK_FREQ / (UART_BPS * OVERSAMPLE);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [SW-1:0] S_FIRST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state;
  logic            sync1;
  logic            rxd_s;
  logic [DW-1:0]   div_cnt;
  logic            running;
  logic            tick;
  logic [SW-1:0]   s_cnt;
  logic [2:0]      bit_idx;
  logic            smp_a;
  logic            smp_b;
  logic            maj;
  logic            dec_tick;
  logic [7:0]      shreg;
  logic            push_req;

  // Two-flop synchronizer; resets to the idle line level so no false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      rxd_s <= sync1;
    end
  end

  // Sample-tick divider, frozen at 0 whenever no frame is in progress so the
  // first tick lands a fixed distance after the start edge.
  assign running = (state == START) || (state == DATA) || (state == STOP);
  assign tick    = running && (div_cnt == D_LAST);

  always_ff @(posedge clk) begin
    if (rst || !running || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // The third sample is the live rxd_s on the decision tick itself.
  assign maj      = (smp_a & smp_b) | (smp_a & rxd_s) | (smp_b & rxd_s);
  assign dec_tick = tick && (s_cnt == S_DEC);
  assign push_req = (state == STOP) && dec_tick && maj;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_cnt     <= '0;
      bit_idx   <= '0;
      smp_a     <= 1'b1;
      smp_b     <= 1'b1;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (tick) begin
        if (s_cnt == S_FIRST) smp_a <= rxd_s;
        if (s_cnt == S_MID)   smp_b <= rxd_s;
        s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          s_cnt   <= '0;
          bit_idx <= '0;
          if (!rxd_s) state <= START;
        end
        START: begin
          if (dec_tick && maj) begin
            state <= IDLE;               // too short to be a start bit
          end else if (tick && (s_cnt == S_LAST)) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (dec_tick) shreg <= {maj, shreg[7:1]};   // LSB arrives first
          if (tick && (s_cnt == S_LAST)) begin
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          // Leave at the decision point so a start edge inside the remaining
          // half of the stop bit is caught.
          if (dec_tick) begin
            if (maj) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state <= IDLE;      // one frame_err per break
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output FIFO.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          push;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push    = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // Memory is not reset; masking keeps m_data at 0 while empty.
  assign m_data     = m_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Oversampling UART receiver with majority-vote bit sampling, framing-error detection and an output FIFO with a valid/ready interface. It is the receive end of the team's 8N1 serial link. It gives downstream logic buffered bytes, so a slow consumer does not lose characters during back-to-back frames. It sits between the board RX pin and command-parsing or loopback logic, alongside the existing transmit path.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
UART_BPS, 115200, line baud rate
OVERSAMPLE, 16, samples per bit; even, at least 8
FIFO_DEPTH, 16, output FIFO entries; power of 2, at least 2

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
uart_rxd  input  1  asynchronous serial line; idle high
m_data  output  8  FIFO head byte; valid when m_valid=1
m_valid  output  1  FIFO not empty
m_ready  input  1  consumer accepts the head byte
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently stored
frame_err  output  1  one-cycle pulse when a received stop bit is 0
overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full

Behaviour:
- Reset (rst=1 at a clk edge):
  - synchronizer flops set to 1; FSM goes to IDLE.
  - FIFO pointers and count cleared.
  - m_valid=0, m_data=0 (memory contents don't-care), fifo_count=0, frame_err=0, overflow=0.
  - Reset mid-frame abandons the partial byte; no flag is raised.
- Input synchronizer: two flops on uart_rxd; "rxd_s" below is the second flop's output.
- Sample tick:
  - TICK_DIV = CLK_FREQ/(UART_BPS*OVERSAMPLE), integer floor, minimum 1.
  - The divider is held at 0 in IDLE and WAIT_HIGH.
  - Otherwise it pulses "tick" once every TICK_DIV clocks, first pulse TICK_DIV clocks after leaving IDLE.
- Sample counter:
  - s_cnt runs 0..OVERSAMPLE-1, advanced on each tick, wrapping at each bit boundary.
  - Bit value = majority of the samples taken at s_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit decision is made on the tick where s_cnt = OVERSAMPLE/2+1 (the "decision tick").
- FSM states:
  - IDLE: when rxd_s=0, go to START with s_cnt=0 and bit index=0.
  - START: at the decision tick, if majority=1 (glitch), return to IDLE with no output. Otherwise, at the tick ending the bit (s_cnt=OVERSAMPLE-1), go to DATA.
  - DATA: eight bits, LSB first. Each decided bit shifts into the shift register. After bit 7 ends, go to STOP.
  - STOP: at the decision tick:
    - majority=1: issue a push request this cycle and go to IDLE immediately. This allows resync on the next start edge within the stop bit.
    - majority=0: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s=1, then go to IDLE. A held break yields exactly one frame_err.
- FIFO (first-word fall-through):
  - m_valid = (fifo_count != 0); m_data = mem[rd_ptr].
  - Pop happens when m_valid && m_ready.
  - Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - If full with no pop, the byte is dropped and overflow pulses that cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count saturates naturally at FIFO_DEPTH.
  - Latency: m_valid/fifo_count update on the clock edge after the stop decision tick (empty FIFO → m_valid=1 one cycle later).
- Line-to-data latency: about 9.5 bit times from the start edge, plus 2 clocks synchronizer and 1 clock FIFO.

Test Plan:
Bench parameters: CLK_FREQ=16000000, UART_BPS=1000000, OVERSAMPLE=16, FIFO_DEPTH=16. This gives TICK_DIV=1 and a bit time of 16 clocks.
- Single byte: drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with m_ready=0 → m_valid rises once; m_data=0xA5; fifo_count=1; no flags. Then m_ready=1 for 1 cycle → m_valid=0, fifo_count=0.
- Glitch rejection: rxd low for 4 clocks, then high → no push, no frame_err, FSM back in IDLE. A following 0x3C frame is received correctly.
- Framing error: 0x3C frame with stop bit driven 0, line held low 40 more clocks, then high → exactly one frame_err pulse, fifo_count stays 0. A following 0x5A frame is received as 0x5A.
- Overflow: m_ready=0, send back-to-back bytes 0x00..0x10 (17 frames) → fifo_count=16, one overflow pulse on the 17th frame. Draining with m_ready=1 yields 0x00..0x0F in order, then m_valid=0.
- Full with simultaneous pop: fill with 16 bytes, then assert m_ready=1 exactly in the cycle the 17th byte (0x77) pushes → no overflow, fifo_count stays 16, 0x77 is read out last.
- Reset mid-frame: assert rst for 1 cycle during bit 4 of 0xFF with 3 bytes queued → fifo_count=0, m_valid=0, no flags. The next complete 0x81 frame is received as 0x81; a baud-slow frame (17 clocks/bit) of 0xC3 is also received correctly.
